lspc2_clk_monitor: RTL
======================

Name: lspc2_clk_monitor

Overview:
- Receiving end of the LSPC2 clock divider interface.
- Samples the six divided LSPC clocks in the CLK_24M domain and produces single-cycle rising-edge clock-enable strobes for downstream synchronous logic.
- Reconstructs the divider phase from the sampled clocks and checks it every cycle against the divider's fixed relationships.
- A lock state machine and a saturating error counter report whether the incoming clock set is coherent.

Parameters:
- LOCK_COUNT, 48, consecutive error-free CLK_24M cycles required to declare lock (range 1..255).
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK_24M  in  1  master clock; all state updates on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- LSPC_12M  in  1  divided clock, counter bit 0.
- LSPC_6M  in  1  divided clock, counter bit 1.
- LSPC_3M  in  1  divided clock, counter bit 2.
- LSPC_1_5M  in  1  divided clock, counter bit 3.
- LSPC_8M  in  1  divide-by-3 clock.
- LSPC_4M  in  1  divide-by-6 clock; toggles on LSPC_8M rising edges.
- CE_12M, CE_6M, CE_3M, CE_1_5M, CE_8M, CE_4M  out  1 each  one-cycle rising-edge strobes.
- PHASE16  out  4  sampled {1_5M,3M,6M,12M}.
- PHASE3  out  2  8M phase, 0..2.
- LOCKED  out  1  clock set coherent.
- PHASE_ERR  out  1  one-cycle pulse on a detected inconsistency while LOCKED.
- ERR_COUNT  out  ERR_W  saturating count of PHASE_ERR pulses.

Behaviour:
- Reset values: all outputs 0. Internal sample and previous-sample registers 0. FSM in UNLOCKED. "First" flag set.
- Sampling: on each rising edge, register all six inputs into S. The previous value of S moves to P. Inputs change on CLK_24M falling edges, so one register stage is sufficient and no synchronizer is used.
- Strobes:
  - CE_x is registered: CE_x <= S_x & ~P_x.
  - Latency is 2 rising edges from an input rising to its CE going high. Width is exactly 1 cycle.
  - While "first" is set (first cycle after reset), all CE are forced to 0.
- PHASE16 is registered from S, with 1 cycle latency.
- PHASE3:
  - Set to 0 in the cycle CE_8M asserts, otherwise incremented.
  - 2 wraps to 0.
  - Before the first 8M edge it holds 0.
- Consistency checks, evaluated each cycle once "first" is clear:
  - (a) S_nibble == P_nibble + 1 mod 16; 15 -> 0 is legal.
  - (b) An 8M rising edge occurs exactly 3 cycles after the previous one. The check is armed after the first edge seen.
  - (c) S_4M != P_4M only in cycles where an 8M rising edge is detected.
  - GOOD means all armed checks pass.
- FSM:
  - UNLOCKED: GOOD increments the good-count; !GOOD clears it. When good-count reaches LOCK_COUNT-1 with GOOD -> LOCKED and LOCKED=1 on the next edge.
  - LOCKED: !GOOD -> UNLOCKED, LOCKED=0, PHASE_ERR=1 for one cycle, ERR_COUNT += 1 (saturating at all-ones), good-count cleared.
  - Errors while UNLOCKED do not pulse PHASE_ERR and do not count.
- Reset asserted mid-operation returns every register to its reset value immediately. After release, the sequence restarts from the "first" cycle.
- CE outputs are never gated by LOCKED.

Test Plan:
- Reference-divider waveform (nibble counting 0..15 each 24M cycle, 8M period 3, 4M period 6) from reset:
  - LOCKED rises on the edge after 48 good cycles.
  - CE_12M pulses every 2 cycles, CE_1_5M every 16, CE_8M every 3, CE_4M every 6.
  - PHASE3 cycles 0,1,2.
  - ERR_COUNT stays 0.
- Nibble wrap 15 -> 0: no error. Inject skip 5 -> 7 while LOCKED: LOCKED falls, one PHASE_ERR pulse, ERR_COUNT=1, relock after 48 further good cycles.
- Stretch one 8M period to 4 cycles while LOCKED: PHASE_ERR once, ERR_COUNT increments, LOCKED=0.
- Toggle LSPC_4M in a non-8M-edge cycle: error flagged. With ERR_W=8, force 300 errors: ERR_COUNT saturates at 255.
- Stuck inputs (all 0) from reset: LOCKED never asserts, no CE pulses, PHASE_ERR never pulses.
- Assert nRESET mid-lock: all outputs 0 asynchronously. After release, first-cycle CE suppression holds and relock takes 48 good cycles.

Source files
------------

// File: rtl/lspc2_clk_monitor.sv
// LSPC2 clock monitor: samples the six divided LSPC clocks in the CLK_24M
// domain, turns their rising edges into single-cycle clock enables, rebuilds
// the divider phase and checks the clock set for coherence every cycle.
module lspc2_clk_monitor #(
    parameter int LOCK_COUNT = 48,
    parameter int ERR_W      = 8
) (
    input  logic             CLK_24M,
    input  logic             nRESET,
    input  logic             LSPC_12M,
    input  logic             LSPC_6M,
    input  logic             LSPC_3M,
    input  logic             LSPC_1_5M,
    input  logic             LSPC_8M,
    input  logic             LSPC_4M,
    output logic             CE_12M,
    output logic             CE_6M,
    output logic             CE_3M,
    output logic             CE_1_5M,
    output logic             CE_8M,
    output logic             CE_4M,
    output logic [3:0]       PHASE16,
    output logic [1:0]       PHASE3,
    output logic             LOCKED,
    output logic             PHASE_ERR,
    output logic [ERR_W-1:0] ERR_COUNT
);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_t;

    localparam logic [7:0]       LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    // Bit order of s/p: {4M, 8M, 1_5M, 3M, 6M, 12M}
    logic [5:0]  s;
    logic [5:0]  p;
    logic        primed;
    logic        first;
    logic [5:0]  ce_q;
    logic [2:0]  gap;
    logic        armed;
    logic [7:0]  good_count;
    logic [7:0]  good_count_next;
    logic        err_pulse;
    lock_state_t state;
    lock_state_t state_next;

    logic rise_8m;
    logic nib_ok;
    logic gap_ok;
    logic ok_4m;
    logic good;

    assign rise_8m = s[4] & ~p[4];
    assign nib_ok  = (s[3:0] == (p[3:0] + 4'd1));
    assign gap_ok  = rise_8m ? (gap == 3'd3) : (gap < 3'd3);
    assign ok_4m   = (s[5] == p[5]) | rise_8m;
    assign good    = nib_ok & (~armed | gap_ok) & ok_4m;

    assign {CE_4M, CE_8M, CE_1_5M, CE_3M, CE_6M, CE_12M} = ce_q;
    assign LOCKED = (state == ST_LOCKED);

    // Sample the inputs and keep one previous sample; "first" stays set until
    // p holds a real sample, so no edge is invented from the reset value.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            s      <= 6'd0;
            p      <= 6'd0;
            primed <= 1'b0;
            first  <= 1'b1;
        end else begin
            s      <= {LSPC_4M, LSPC_8M, LSPC_1_5M, LSPC_3M, LSPC_6M, LSPC_12M};
            p      <= s;
            primed <= 1'b1;
            first  <= ~primed;
        end
    end

    // Rising-edge strobes and the registered counter nibble.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            ce_q    <= 6'd0;
            PHASE16 <= 4'd0;
        end else begin
            ce_q    <= first ? 6'd0 : (s & ~p);
            PHASE16 <= s[3:0];
        end
    end

    // Track the 8M period: distance since the last rise and the 0..2 phase.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            gap    <= 3'd0;
            armed  <= 1'b0;
            PHASE3 <= 2'd0;
        end else if (!first) begin
            if (rise_8m) begin
                gap    <= 3'd1;
                armed  <= 1'b1;
                PHASE3 <= 2'd0;
            end else begin
                if (gap != 3'd7) begin
                    gap <= gap + 3'd1;
                end
                if (armed) begin
                    PHASE3 <= (PHASE3 == 2'd2) ? 2'd0 : PHASE3 + 2'd1;
                end
            end
        end
    end

    // Lock FSM next-state: count good cycles to lock, drop out on any error.
    always_comb begin
        state_next      = state;
        good_count_next = good_count;
        err_pulse       = 1'b0;
        if (!first) begin
            case (state)
                ST_UNLOCKED: begin
                    if (!good) begin
                        good_count_next = 8'd0;
                    end else if (good_count == LOCK_LAST) begin
                        state_next      = ST_LOCKED;
                        good_count_next = 8'd0;
                    end else begin
                        good_count_next = good_count + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        state_next      = ST_UNLOCKED;
                        good_count_next = 8'd0;
                        err_pulse       = 1'b1;
                    end
                end
                default: begin
                    state_next      = ST_UNLOCKED;
                    good_count_next = 8'd0;
                end
            endcase
        end
    end

    // Lock FSM state plus the error pulse and its saturating counter.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state      <= ST_UNLOCKED;
            good_count <= 8'd0;
            PHASE_ERR  <= 1'b0;
            ERR_COUNT  <= '0;
        end else begin
            state      <= state_next;
            good_count <= good_count_next;
            PHASE_ERR  <= err_pulse;
            if (err_pulse && (ERR_COUNT != ERR_MAX)) begin
                ERR_COUNT <= ERR_COUNT + ERR_ONE;
            end
        end
    end

endmodule
